alu_seq_core: RTL and testbench
===============================

# alu_seq_core

Parametrised, sequential successor to the 32-bit combinational ALU. It accepts one operation per transaction over a valid/ready handshake and returns a registered result with four fully defined flags (C, V, Z, N). It adds an iterative multiplier, variable shifts and add-with-carry from a stored carry flag. It sits between the operand/opcode front end and the result/LED back end.

## Interface
- WIDTH, 32: datapath width; legal values are multiples of 8 with WIDTH ≥ 8.
- CNT_W, $clog2(WIDTH)+1: width of the multiply iteration counter.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in_valid  in  1  operation presented.
- in_ready  out  1  block can accept; a transfer occurs on an edge where in_valid && in_ready.
- op  in  4  opcode.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- out_valid  out  1  result/flags valid.
- out_ready  in  1  consumer takes the result; retires on an edge where out_valid && out_ready.
- result  out  WIDTH  registered result.
- cf, vf, zf, nf  out  1 each  registered carry, overflow, zero and sign flags for result.

## Operation
- Opcodes and results:
  - 0 ADD: a+b
  - 1 SUB: a+~b+1
  - 2 INC: a+1
  - 3 DEC: a-1
  - 4 PASS: a
  - 5 SHL1: a<<1
  - 6 LANEADD: independent 8-bit adds per byte lane, with no carry between lanes
  - 7 AND, 8 OR, 9 XOR
  - A NOT: ~a
  - B NEG: ~a+1
  - C MUL: low WIDTH bits of a*b, unsigned, iterative
  - D SHR: a>>b[CNT_W-2:0], logical
  - E SAR: arithmetic shift right by the same amount
  - F ADC: a+b+c_q
- Carry flag (cf):
  - Add-class ops (ADD, SUB, INC, DEC, NEG, ADC): cf = carry-out of the WIDTH+1-bit sum. For SUB, cf=1 means no borrow.
  - SHL1: cf = a[WIDTH-1].
  - All other ops: cf = 0.
- Overflow flag (vf):
  - Add-class ops: signed overflow.
    - Addition: operands share a sign that differs from the result sign.
    - Subtraction: operand signs differ and the result sign differs from a's sign.
  - All other ops: vf = 0.
- Zero and sign flags, every op: zf = (result==0); nf = result[WIDTH-1].
- Stored carry c_q:
  - Internal register, updated with cf whenever a result is written into the output register.
  - ADC uses the c_q value as of its accept edge. This includes a carry produced by a previous, not yet retired op.
- State machine:
  - IDLE → DONE: single-cycle op accepted.
  - IDLE → BUSY: MUL accepted; operands latched, counter=0, accumulator=0.
  - BUSY: one shift-add step per cycle (acc += b_shift if a_shift[0]; a_shift>>=1; b_shift<<=1). Counter increments each step; after WIDTH steps, acc is written to result and the state becomes DONE.
  - DONE → IDLE: out_ready=1 and in_valid=0.
  - DONE → DONE: out_ready=1 and a new single-cycle op is accepted in the same cycle.
  - DONE → BUSY: out_ready=1 and a MUL is accepted in the same cycle.
  - DONE, out_ready=0: hold.
- in_ready = (state==IDLE) || (state==DONE && out_ready). It is combinational and 0 throughout BUSY.
- Illegal conditions do not exist: all 16 opcodes are defined. A shift amount ≥ WIDTH yields 0 for SHR, or all-sign bits for SAR.

## Timing
- Reset values: out_valid=0, result=0, cf=vf=zf=nf=0, c_q=0, state=IDLE. in_ready therefore reads 1 during and after reset.
- Single-cycle op accepted at edge k: result and flags are visible after edge k, out_valid=1 from edge k (latency 1).
- MUL accepted at edge k: out_valid=1 after edge k+WIDTH (latency WIDTH+1 cycles counted from the accept cycle).
- Throughput:
  - Single-cycle ops: one per cycle with out_ready held 1.
  - MUL: one per WIDTH+1 cycles.
- Backpressure: while out_valid && !out_ready, result and all flags are held stable and in_ready=0.
- Reset asserted mid-operation (any state): outputs return to reset values immediately. The in-flight op is discarded and produces no result.
- Operands a/b/op are sampled only on the accept edge; later changes do not affect an in-flight MUL.

## Test plan
- WIDTH=32, ADD a=0x7FFFFFFF b=0x00000001 → result=0x80000000, vf=1, nf=1, cf=0, zf=0; out_valid one cycle after accept.
- SUB 5−5 → result=0, zf=1, cf=1. Then, back-to-back, ADC a=0xFFFFFFFF b=0 → result=0, cf=1, zf=1, because c_q=1 came from the SUB.
- MUL a=0x00010003 b=0x00010002 → result=0x00050006. in_ready=0 for 32 cycles; out_valid rises exactly 32 edges after the accept edge; a changed during BUSY has no effect.
- LANEADD a=0xFF01FF80 b=0x01010180 → result=0x00020000, cf=0, vf=0.
- Backpressure: hold out_ready=0 for 3 cycles after a result → result/flags stable and in_ready=0. Raise out_ready with in_valid=1 (XOR) → retire and accept on the same edge; new result next cycle.
- Reset mid-MUL: drop rst_n at the 10th BUSY cycle → out_valid=0, result=0, flags=0, in_ready=1 immediately. After release, an INC of 0xFFFFFFFF → result=0, cf=1, zf=1.

Source files
------------

// File: rtl/alu_seq_core.sv
// Sequential ALU with valid/ready handshake, registered result and C/V/Z/N flags.
// Single-cycle ops complete on the accept edge; MUL iterates one shift-add step per cycle.
module alu_seq_core #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cf,
  output logic             vf,
  output logic             zf,
  output logic             nf
);

  localparam logic [3:0] OpAdd  = 4'h0, OpSub  = 4'h1, OpInc = 4'h2, OpDec = 4'h3;
  localparam logic [3:0] OpPass = 4'h4, OpShl1 = 4'h5, OpLane = 4'h6, OpAnd = 4'h7;
  localparam logic [3:0] OpOr   = 4'h8, OpXor  = 4'h9, OpNot = 4'hA, OpNeg = 4'hB;
  localparam logic [3:0] OpMul  = 4'hC, OpShr  = 4'hD, OpSar = 4'hE, OpAdc = 4'hF;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cf_q, cf_d, vf_q, vf_d, zf_q, zf_d, nf_q, nf_d;
  logic             c_q, c_d;
  logic [WIDTH-1:0] acc_q, acc_d, a_sh_q, a_sh_d, b_sh_q, b_sh_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             accept;
  logic [WIDTH-1:0] add_x, add_y;
  logic             add_cin;
  logic [WIDTH:0]   add_sum;
  logic             add_vf;
  logic [WIDTH-1:0] lane_res;
  logic [CNT_W-2:0] shamt;
  logic [WIDTH-1:0] alu_res;
  logic             alu_cf, alu_vf;
  logic [WIDTH-1:0] acc_step;

  assign in_ready  = (state_q == StIdle) || ((state_q == StDone) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == StDone);
  assign result    = result_q;
  assign cf        = cf_q;
  assign vf        = vf_q;
  assign zf        = zf_q;
  assign nf        = nf_q;

  // All add-class ops map onto one adder: x + y + cin.
  always_comb begin
    add_x   = a;
    add_y   = b;
    add_cin = 1'b0;
    unique case (op)
      OpSub:   begin add_y = ~b;            add_cin = 1'b1; end
      OpInc:   begin add_y = '0;            add_cin = 1'b1; end
      OpDec:   begin add_y = '1;            add_cin = 1'b0; end
      OpNeg:   begin add_x = ~a; add_y = '0; add_cin = 1'b1; end
      OpAdc:   begin add_cin = c_q; end
      default: ;
    endcase
  end

  assign add_sum = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_cin};
  assign add_vf  = (add_x[WIDTH-1] == add_y[WIDTH-1]) && (add_sum[WIDTH-1] != add_x[WIDTH-1]);
  assign shamt   = b[CNT_W-2:0];

  always_comb begin
    lane_res = '0;
    for (int i = 0; i < int'(WIDTH / 8); i++) begin
      lane_res[8*i +: 8] = a[8*i +: 8] + b[8*i +: 8];
    end
  end

  always_comb begin
    alu_res = '0;
    alu_cf  = 1'b0;
    alu_vf  = 1'b0;
    unique case (op)
      OpAdd, OpSub, OpInc, OpDec, OpNeg, OpAdc: begin
        alu_res = add_sum[WIDTH-1:0];
        alu_cf  = add_sum[WIDTH];
        alu_vf  = add_vf;
      end
      OpPass:  alu_res = a;
      OpShl1:  begin alu_res = a << 1; alu_cf = a[WIDTH-1]; end
      OpLane:  alu_res = lane_res;
      OpAnd:   alu_res = a & b;
      OpOr:    alu_res = a | b;
      OpXor:   alu_res = a ^ b;
      OpNot:   alu_res = ~a;
      OpShr:   alu_res = a >> shamt;
      OpSar:   alu_res = $unsigned($signed(a) >>> shamt);
      default: alu_res = '0;
    endcase
  end

  assign acc_step = a_sh_q[0] ? (acc_q + b_sh_q) : acc_q;

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    cf_d     = cf_q;
    vf_d     = vf_q;
    zf_d     = zf_q;
    nf_d     = nf_q;
    c_d      = c_q;
    acc_d    = acc_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (state_q == StDone && out_ready && !in_valid) state_d = StIdle;
        if (accept) begin
          if (op == OpMul) begin
            state_d = StBusy;
            a_sh_d  = a;
            b_sh_d  = b;
            acc_d   = '0;
            cnt_d   = '0;
          end else begin
            state_d  = StDone;
            result_d = alu_res;
            cf_d     = alu_cf;
            vf_d     = alu_vf;
            zf_d     = (alu_res == '0);
            nf_d     = alu_res[WIDTH-1];
            c_d      = alu_cf;
          end
        end
      end
      StBusy: begin
        acc_d  = acc_step;
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q << 1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d  = StDone;
          result_d = acc_step;
          cf_d     = 1'b0;
          vf_d     = 1'b0;
          zf_d     = (acc_step == '0);
          nf_d     = acc_step[WIDTH-1];
          c_d      = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      result_q <= '0;
      cf_q     <= 1'b0;
      vf_q     <= 1'b0;
      zf_q     <= 1'b0;
      nf_q     <= 1'b0;
      c_q      <= 1'b0;
      acc_q    <= '0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      cf_q     <= cf_d;
      vf_q     <= vf_d;
      zf_q     <= zf_d;
      nf_q     <= nf_d;
      c_q      <= c_d;
      acc_q    <= acc_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_alu_seq_core.sv
// Scoreboard bench for alu_seq_core: expectations queued at accept, compared at retire.
module tb_alu_seq_core;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  op = 4'h0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        cf, vf, zf, nf;

  typedef struct packed {
    logic [31:0] res;
    logic        c, v, z, n;
  } exp_t;

  exp_t q[$];
  logic c_model = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  alu_seq_core #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cf        (cf),
    .vf        (vf),
    .zf        (zf),
    .nf        (nf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                                 input logic cin);
    exp_t        e;
    logic [32:0] s;
    logic [63:0] p;
    logic [31:0] r;
    logic        c, v;
    s = '0; p = '0; r = '0; c = 1'b0; v = 1'b0;
    case (o)
      4'h0: begin s = {1'b0, x} + {1'b0, y};
                  v = (x[31] == y[31]) && (s[31] != x[31]); end
      4'h1: begin s = {1'b0, x} + {1'b0, ~y} + 33'd1;
                  v = (x[31] != y[31]) && (s[31] != x[31]); end
      4'h2: begin s = {1'b0, x} + 33'd1; v = (x == 32'h7FFF_FFFF); end
      4'h3: begin s = {1'b0, x} + 33'h0_FFFF_FFFF; v = (x == 32'h8000_0000); end
      4'h4: r = x;
      4'h5: begin r = {x[30:0], 1'b0}; c = x[31]; end
      4'h6: for (int i = 0; i < 4; i++) r[8*i +: 8] = x[8*i +: 8] + y[8*i +: 8];
      4'h7: r = x & y;
      4'h8: r = x | y;
      4'h9: r = x ^ y;
      4'hA: r = ~x;
      4'hB: begin s = {1'b0, ~x} + 33'd1; v = (x == 32'h8000_0000); end
      4'hC: begin p = {32'd0, x} * {32'd0, y}; r = p[31:0]; end
      4'hD: r = x >> y[4:0];
      4'hE: r = $unsigned($signed(x) >>> y[4:0]);
      default: begin s = {1'b0, x} + {1'b0, y} + {32'd0, cin};
                     v = (x[31] == y[31]) && (s[31] != x[31]); end
    endcase
    if (o inside {4'h0, 4'h1, 4'h2, 4'h3, 4'hB, 4'hF}) begin
      r = s[31:0];
      c = s[32];
    end
    e.res = r; e.c = c; e.v = v; e.z = (r == 0); e.n = r[31];
    return e;
  endfunction

  // Present one op, queue its expectation just before the accept edge, return at edge+1.
  task automatic do_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    int   n;
    in_valid = 1'b1; op = o; a = x; b = y;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("accept_timeout", 64'(n), 64'd0);
    e = model(o, x, y, c_model);
    q.push_back(e);
    c_model = (o == 4'hC) ? 1'b0 : e.c;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        check("sb_underflow", 64'd0, 64'd1);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("sb_result", {28'd0, result, cf, vf, zf, nf}, {28'd0, e});
      end
    end
  end

  initial begin
    int lat, busy, n;
    // Reset state
    #2;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result", {28'd0, result, cf, vf, zf, nf}, 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // ADD overflow, latency 1
    do_op(4'h0, 32'h7FFF_FFFF, 32'h1);
    check("add_latency", 64'(out_valid), 64'd1);
    check("add_flags", {28'd0, result, cf, vf, zf, nf}, {28'd0, 32'h8000_0000, 4'b0101});

    // SUB then ADC consuming stored carry
    do_op(4'h1, 32'd5, 32'd5);
    check("sub_flags", {28'd0, result, cf, vf, zf, nf}, {28'd0, 32'h0, 4'b1010});
    do_op(4'hF, 32'hFFFF_FFFF, 32'h0);
    check("adc_flags", {28'd0, result, cf, vf, zf, nf}, {28'd0, 32'h0, 4'b1010});

    // MUL latency and operand isolation
    do_op(4'hC, 32'h0001_0003, 32'h0001_0002);
    a = 32'hDEAD_BEEF; b = 32'h1234_5678;
    lat = 0; busy = 0;
    while (!out_valid && lat < 100) begin
      if (!in_ready) busy++;
      @(posedge clk); #1;
      lat++;
    end
    check("mul_latency", 64'(lat), 64'd32);
    check("mul_busy_ready", 64'(busy), 64'd32);
    check("mul_result", 64'(result), 64'h0005_0006);

    // LANEADD
    do_op(4'h6, 32'hFF01_FF80, 32'h0101_0180);
    check("lane_flags", {28'd0, result, cf, vf, zf, nf}, {28'd0, 32'h0002_0000, 4'b0000});

    // Boundary ops
    do_op(4'hE, 32'h8000_0000, 32'd31);
    do_op(4'hD, 32'h8000_0000, 32'd31);
    do_op(4'h3, 32'h0, 32'h0);
    do_op(4'hB, 32'h8000_0000, 32'h0);
    do_op(4'h1, 32'h0, 32'h1);
    do_op(4'h5, 32'h8000_0001, 32'h0);
    do_op(4'h2, 32'h7FFF_FFFF, 32'h0);

    // Backpressure
    @(posedge clk); #1;
    out_ready = 1'b0;
    do_op(4'h8, 32'h0000_F0F0, 32'h0000_0F0F);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("bp_hold", {28'd0, result, cf, vf, zf, nf}, {28'd0, 32'h0000_FFFF, 4'b0000});
      check("bp_ready", {62'd0, in_ready, out_valid}, 64'b01);
    end
    out_ready = 1'b1;
    do_op(4'h9, 32'hA5A5_0000, 32'h0F0F_0000);
    check("bp_next", {31'd0, out_valid, result}, {31'd1, 32'hAAAA_0000});

    // Reset mid-MUL
    do_op(4'hC, 32'd3, 32'd5);
    repeat (9) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check("midrst_out", {28'd0, result, cf, vf, zf, nf}, 64'd0);
    check("midrst_hs", {62'd0, in_ready, out_valid}, 64'b10);
    q.delete();
    c_model = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_op(4'h2, 32'hFFFF_FFFF, 32'h0);
    check("inc_after_rst", {28'd0, result, cf, vf, zf, nf}, {28'd0, 32'h0, 4'b1010});

    // Random mix
    for (int i = 0; i < 40; i++) begin
      do_op(4'($urandom_range(0, 15)), $urandom, $urandom);
    end

    // Drain
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("sb_drain", 64'(q.size()), 64'd0);
    @(posedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
